mem8x8_ctrl: RTL and testbench

- Sequencing controller and two-requester arbiter for the 8x8 storage array (eight byte cells, each with shared inp/rw and a private sel, plus outp).
- Accepts byte read and write requests from two clients (A, B) and arbitrates round-robin.
- Drives one-hot byte select, rw and write data into the array, and returns read data with a one-cycle ack pulse.
- Sits between the array and any bus-side logic; it is the only driver of the array's sel/rw/inp.

---
 rtl/mem8x8_pkg.sv | 27 ++
 rtl/mem8x8_ctrl_if.sv | 41 ++++
 rtl/mem8x8_ctrl_rr_arb2.sv | 17 +
 rtl/mem8x8_ctrl.sv | 138 +++++++++++++
 tb/tb_mem8x8_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem8x8_pkg.sv
// mem8x8_pkg: shared constants for the 8x8 storage array controller.
//   DATA_W / DEPTH / ADDR_W : array geometry defaults
//   state_t                 : controller state encoding
//   CLI_A / CLI_B           : client identifiers (also the last_grant encoding)
//   sel_of()                : address to one-hot byte select
package mem8x8_pkg;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    DONE   = 3'd3,
    VERIFY = 3'd4
  } state_t;

  localparam logic CLI_A = 1'b0;
  localparam logic CLI_B = 1'b1;

  function automatic logic [DEPTH-1:0] sel_of(input logic [ADDR_W-1:0] a);
    return DEPTH'(1) << a;
  endfunction

endpackage

// File: rtl/mem8x8_ctrl_if.sv
// mem8x8_ctrl_if: client-side bus of the 8x8 array controller.
//   req_x/we_x/addr_x/wdata_x : request from client x (A or B), held until ack_x
//   ack_x                     : one-cycle completion pulse to client x
//   rdata                     : read data, valid in the ack cycle of a read
//   busy                      : controller not in IDLE
//   err                       : write readback mismatch (only with MEM8X8_CTRL_READBACK_EN)
// Modports: master = client side, slave = controller side.
interface mem8x8_ctrl_if;
  import mem8x8_pkg::*;

  logic              req_a, we_a, ack_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              req_b, we_b, ack_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic [DATA_W-1:0] rdata;
  logic              busy;
`ifdef MEM8X8_CTRL_READBACK_EN
  logic              err;
`endif

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
`ifdef MEM8X8_CTRL_READBACK_EN
    input  err,
`endif
    input  ack_a, ack_b, rdata, busy
  );

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
`ifdef MEM8X8_CTRL_READBACK_EN
    output err,
`endif
    output ack_a, ack_b, rdata, busy
  );

endinterface

// File: rtl/mem8x8_ctrl_rr_arb2.sv
// rr_arb2: combinational two-input round-robin arbiter.
//   req[1:0]   : request, bit 0 = client A, bit 1 = client B
//   last_grant : client granted most recently (CLI_A / CLI_B), held by parent
//   grant[1:0] : one-hot grant, zero when no request
module rr_arb2
  import mem8x8_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // On a tie the client that did not win last time gets the grant.
  assign grant[0] = req[0] & (~req[1] | (last_grant == CLI_B));
  assign grant[1] = req[1] & (~req[0] | (last_grant == CLI_A));

endmodule

// File: rtl/mem8x8_ctrl.sv
// mem8x8_ctrl: sequencing controller and two-client round-robin arbiter
// for the 8x8 storage array. Sole driver of the array's sel/rw/inp.
//   clk, rst_n : system clock (rising edge), async active-low reset
//   bus        : client bus (mem8x8_ctrl_if.slave)
//   mem_sel    : one-hot byte select to the array
//   mem_rw     : 1 = write strobe, 0 = read/hold
//   mem_inp    : write data to the array
//   mem_outp   : muxed read data from the array
// Optional build macro MEM8X8_CTRL_READBACK_EN adds a VERIFY state that
// reads each written byte back and drives bus.err on mismatch.
//
// state  | meaning
// IDLE   | waiting for a request; grants and latches fields
// SETUP  | select driven, rw low, address settling
// ACCESS | write strobe or read capture
// VERIFY | write readback compare (readback build only)
// DONE   | select released, ack pulse to the owner
module mem8x8_ctrl
  import mem8x8_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  mem8x8_ctrl_if.slave      bus,
  output logic [DEPTH-1:0]  mem_sel,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_inp,
  input  logic [DATA_W-1:0] mem_outp
);

  state_t            state;
  logic              owner;
  logic              last_grant;
  logic              lat_we;
  logic [1:0]        grant;
  logic              ack_a, ack_b, busy;
  logic [DATA_W-1:0] rdata;
`ifdef MEM8X8_CTRL_READBACK_EN
  logic [DATA_W-1:0] lat_wdata;
  logic              err;
  assign bus.err = err;
`endif

  rr_arb2 u_arb (
    .req        ({bus.req_b, bus.req_a}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign bus.ack_a = ack_a;
  assign bus.ack_b = ack_b;
  assign bus.rdata = rdata;
  assign bus.busy  = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= CLI_A;
      last_grant <= CLI_B;
      lat_we     <= 1'b0;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      busy       <= 1'b0;
      rdata      <= '0;
      mem_sel    <= '0;
      mem_rw     <= 1'b0;
      mem_inp    <= '0;
`ifdef MEM8X8_CTRL_READBACK_EN
      lat_wdata  <= '0;
      err        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            owner      <= grant[1] ? CLI_B : CLI_A;
            last_grant <= grant[1] ? CLI_B : CLI_A;
            lat_we     <= grant[1] ? bus.we_b : bus.we_a;
            mem_sel    <= sel_of(grant[1] ? bus.addr_b : bus.addr_a);
            mem_inp    <= grant[1] ? bus.wdata_b : bus.wdata_a;
            mem_rw     <= 1'b0;
            busy       <= 1'b1;
`ifdef MEM8X8_CTRL_READBACK_EN
            lat_wdata  <= grant[1] ? bus.wdata_b : bus.wdata_a;
`endif
            state      <= SETUP;
          end
        end
        SETUP: begin
          mem_rw <= lat_we;
          state  <= ACCESS;
        end
        ACCESS: begin
          if (!lat_we) rdata <= mem_outp;
`ifdef MEM8X8_CTRL_READBACK_EN
          if (lat_we) begin
            // Keep the byte selected so the array presents what was written.
            mem_rw <= 1'b0;
            state  <= VERIFY;
          end else begin
            mem_sel <= '0;
            mem_rw  <= 1'b0;
            ack_a   <= (owner == CLI_A);
            ack_b   <= (owner == CLI_B);
            state   <= DONE;
          end
`else
          mem_sel <= '0;
          mem_rw  <= 1'b0;
          ack_a   <= (owner == CLI_A);
          ack_b   <= (owner == CLI_B);
          state   <= DONE;
`endif
        end
`ifdef MEM8X8_CTRL_READBACK_EN
        VERIFY: begin
          err     <= (mem_outp != lat_wdata);
          mem_sel <= '0;
          mem_rw  <= 1'b0;
          ack_a   <= (owner == CLI_A);
          ack_b   <= (owner == CLI_B);
          state   <= DONE;
        end
`endif
        DONE: begin
          ack_a <= 1'b0;
          ack_b <= 1'b0;
          busy  <= 1'b0;
`ifdef MEM8X8_CTRL_READBACK_EN
          err   <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem8x8_ctrl.sv
module tb_mem8x8_ctrl;
  import mem8x8_pkg::*;

`ifdef MEM8X8_CTRL_READBACK_EN
  localparam int WLAT = 4;
`else
  localparam int WLAT = 3;
`endif
  localparam int RLAT = 3;

  typedef struct {
    int         cli;
    bit         rd;
    logic [7:0] data;
    bit         err;
    int         cyc;
  } exp_t;

  logic             clk, rst_n;
  logic [DEPTH-1:0] mem_sel;
  logic             mem_rw;
  logic [7:0]       mem_inp, mem_outp;
  logic [7:0]       cells [DEPTH];
  bit               corrupt;
  int               cyc;
  int               n_tests, n_fail;
  exp_t             sb [$];

  mem8x8_ctrl_if bus ();

  mem8x8_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_sel  (mem_sel),
    .mem_rw   (mem_rw),
    .mem_inp  (mem_inp),
    .mem_outp (mem_outp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 8x8 array: selected byte written on a clock edge while rw=1.
  always @(posedge clk)
    if (mem_rw)
      for (int i = 0; i < DEPTH; i++)
        if (mem_sel[i]) cells[i] <= mem_inp;

  always_comb begin
    mem_outp = 8'h00;
    for (int i = 0; i < DEPTH; i++)
      if (mem_sel[i]) mem_outp = cells[i];
    if (corrupt) mem_outp = mem_outp ^ 8'hFF;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: protocol invariants every cycle, scoreboard pop on every ack.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("invariant", int'((mem_rw && mem_sel == '0) ||
                            ((mem_sel & (mem_sel - 1'b1)) != '0) ||
                            (bus.ack_a && bus.ack_b)), 0);
      if (bus.ack_a || bus.ack_b) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("ack_client", int'(bus.ack_b), e.cli);
          chk("ack_cycle", cyc, e.cyc);
          if (e.rd) chk("rdata", int'(bus.rdata), int'(e.data));
`ifdef MEM8X8_CTRL_READBACK_EN
          chk("err", int'(bus.err), int'(e.err));
`endif
        end
      end
    end
  end

  task automatic set_req(input int c, input bit we, input logic [2:0] a, input logic [7:0] d);
    if (c == 0) begin
      bus.req_a = 1'b1; bus.we_a = we; bus.addr_a = a; bus.wdata_a = d;
    end else begin
      bus.req_b = 1'b1; bus.we_b = we; bus.addr_b = a; bus.wdata_b = d;
    end
  endtask

  task automatic clr_req(input int c);
    if (c == 0) bus.req_a = 1'b0;
    else        bus.req_b = 1'b0;
  endtask

  task automatic push(input int c, input bit rd, input logic [7:0] d, input bit e, input int at);
    exp_t x;
    x.cli = c; x.rd = rd; x.data = d; x.err = e; x.cyc = at;
    sb.push_back(x);
  endtask

  // Waits for client c's ack, then returns at #1 after the next rising edge.
  task automatic wait_ack(input int c);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = (c == 0) ? bus.ack_a : bus.ack_b;
    end
    if (!seen) chk("ack_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  // Single transaction from an idle controller; caller is at #1 after an edge.
  task automatic txn(input int c, input bit we, input logic [2:0] a, input logic [7:0] d,
                     input logic [7:0] exp_rd);
    set_req(c, we, a, d);
    push(c, !we, exp_rd, 1'b0, cyc + (we ? WLAT : RLAT));
    wait_ack(c);
    clr_req(c);
  endtask

  initial begin
    int c0, got;
    n_tests = 0; n_fail = 0; cyc = 0; corrupt = 1'b0;
    for (int i = 0; i < DEPTH; i++) cells[i] = 8'h00;
    bus.req_a = 0; bus.we_a = 0; bus.addr_a = 0; bus.wdata_a = 0;
    bus.req_b = 0; bus.we_b = 0; bus.addr_b = 0; bus.wdata_b = 0;
    rst_n = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ack", int'({bus.ack_a, bus.ack_b}), 0);
    chk("rst_rdata", int'(bus.rdata), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_sel", int'(mem_sel), 0);
    chk("rst_rw", int'(mem_rw), 0);
    chk("rst_inp", int'(mem_inp), 0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // A writes 0xAA to addr 5 with cycle-by-cycle bus checks
    c0 = cyc;
    set_req(0, 1'b1, 3'd5, 8'hAA);
    push(0, 1'b0, 8'h00, 1'b0, c0 + WLAT);
    @(posedge clk); #1;
    chk("setup_sel", int'(mem_sel), 'h20);
    chk("setup_rw", int'(mem_rw), 0);
    chk("setup_inp", int'(mem_inp), 'hAA);
    chk("setup_busy", int'(bus.busy), 1);
    @(posedge clk); #1;
    chk("access_sel", int'(mem_sel), 'h20);
    chk("access_rw", int'(mem_rw), 1);
    wait_ack(0);
    chk("done_after_sel", int'(mem_sel), 0);
    chk("idle_busy", int'(bus.busy), 0);
    clr_req(0);
    txn(0, 1'b0, 3'd5, 8'h00, 8'hAA);

    // Reset in the ACCESS cycle of a write: no write, no ack
    set_req(0, 1'b1, 3'd5, 8'h55);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_rw", int'(mem_rw), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_sel", int'(mem_sel), 0);
    chk("midrst_rw", int'(mem_rw), 0);
    chk("midrst_ack", int'({bus.ack_a, bus.ack_b}), 0);
    clr_req(0);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1, 1'b0, 3'd5, 8'h00, 8'hAA);

    // Both clients held high for four transactions: A,B,A,B
    c0 = cyc;
    set_req(0, 1'b1, 3'd1, 8'h11);
    set_req(1, 1'b1, 3'd2, 8'h22);
    for (int k = 0; k < 4; k++)
      push(k % 2, 1'b0, 8'h00, 1'b0, c0 + k * (WLAT + 1) + WLAT);
    got = 0;
    for (int k = 0; k < 60 && got < 4; k++) begin
      @(negedge clk);
      if (bus.ack_a || bus.ack_b) got++;
    end
    if (got < 4) chk("rr_timeout", got, 4);
    @(posedge clk); #1;
    clr_req(0); clr_req(1);
    @(posedge clk); #1;
    txn(0, 1'b0, 3'd1, 8'h00, 8'h11);
    txn(1, 1'b0, 3'd2, 8'h00, 8'h22);

    // Writes to both ends of the array, then read back
    txn(1, 1'b1, 3'd0, 8'h0F, 8'h00);
    txn(0, 1'b1, 3'd7, 8'hF0, 8'h00);
    txn(0, 1'b0, 3'd0, 8'h00, 8'h0F);
    txn(1, 1'b0, 3'd7, 8'h00, 8'hF0);

    // Field changes after grant are ignored; busy spans SETUP..DONE
    c0 = cyc;
    set_req(0, 1'b1, 3'd2, 8'h33);
    push(0, 1'b0, 8'h00, 1'b0, c0 + WLAT);
    for (int k = 1; k <= WLAT; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin bus.addr_a = 3'd6; bus.wdata_a = 8'h99; end
      chk("busy_in_txn", int'(bus.busy), 1);
      if (k == 2) chk("latched_sel", int'(mem_sel), 'h04);
    end
    @(posedge clk); #1;
    chk("busy_after", int'(bus.busy), 0);
    chk("rdata_hold", int'(bus.rdata), 'hF0);
    clr_req(0);
    txn(0, 1'b0, 3'd2, 8'h00, 8'h33);
    txn(0, 1'b0, 3'd6, 8'h00, 8'h00);

`ifdef MEM8X8_CTRL_READBACK_EN
    // Readback: clean write gives err=0, corrupted VERIFY read gives err=1
    txn(1, 1'b1, 3'd3, 8'h5A, 8'h00);
    corrupt = 1'b1;
    set_req(0, 1'b1, 3'd4, 8'hC3);
    push(0, 1'b0, 8'h00, 1'b1, cyc + WLAT);
    wait_ack(0);
    clr_req(0);
    corrupt = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
